// File: rtl/shift_register_4.sv
// ---------------------------------------------------------------------------
// shift_register_4
//   4-bit universal shift register: serial shift (either direction), rotate,
//   parallel load and hold, selected by a 2-bit mode code. Both outputs are
//   registered; nothing passes combinationally from inputs to outputs.
//
// Ports
//   CLK      in   1  clock, all state changes on the rising edge
//   RESET_N  in   1  synchronous active-low reset (highest priority)
//   ENB      in   1  enable; 0 freezes Q and S_OUT
//   DIR      in   1  0 = shift/rotate toward Q[3], 1 = toward Q[0]
//   S_IN     in   1  serial fill bit for shift mode
//   MODO     in   2  00 shift, 01 rotate, 10 load, 11 hold
//   D        in   4  parallel load data
//   Q        out  4  register contents
//   S_OUT    out  1  bit shifted out on the last enabled shift edge
//
// Build option
//   SHIFT_REG_ROTATE_EN  defined: MODO=01 rotates.
//                        undefined: MODO=01 acts as hold and the rotate
//                        mux is not built.
// ---------------------------------------------------------------------------
module shift_register_4 (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENB,
    input  logic       DIR,
    input  logic       S_IN,
    input  logic [1:0] MODO,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       S_OUT
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [3:0] q_q, q_d;
    logic       s_out_q, s_out_d;

    // Next-state selection. Disabled cycles keep both registers; every
    // enabled non-shift cycle clears S_OUT. Unknown mode codes land in the
    // default arm, which is the hold behaviour.
    always_comb begin
        q_d     = q_q;
        s_out_d = s_out_q;
        if (ENB) begin
            s_out_d = 1'b0;
            case (MODO)
                MODE_SHIFT: begin
                    if (DIR) begin
                        q_d     = {S_IN, q_q[3:1]};
                        s_out_d = q_q[0];
                    end else begin
                        q_d     = {q_q[2:0], S_IN};
                        s_out_d = q_q[3];
                    end
                end
`ifdef SHIFT_REG_ROTATE_EN
                MODE_ROTATE: begin
                    q_d = DIR ? {q_q[0], q_q[3:1]} : {q_q[2:0], q_q[3]};
                end
`endif
                MODE_LOAD: begin
                    q_d = D;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // Reset is checked ahead of ENB so a disabled register still clears.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            q_q     <= 4'b0000;
            s_out_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
        end
    end

    assign Q     = q_q;
    assign S_OUT = s_out_q;

endmodule

// File: tb/tb_shift_register_4.sv
// ---------------------------------------------------------------------------
// tb_shift_register_4
//   Self-checking bench for shift_register_4. Each drive pushes the expected
//   {Q,S_OUT} onto a scoreboard queue; after the edge the entry is popped
//   and compared. Directed sequences use hand-derived constants, followed by
//   a random phase checked against a small reference model. Rotate results
//   follow SHIFT_REG_ROTATE_EN.
// ---------------------------------------------------------------------------
module tb_shift_register_4;

    logic       clk;
    logic       rst_n;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       s_out;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0] sb_q[$];

    // reference state for the random phase
    logic [3:0] m_q;
    logic       m_s;

    shift_register_4 dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .ENB    (enb),
        .DIR    (dir),
        .S_IN   (s_in),
        .MODO   (modo),
        .D      (d),
        .Q      (q),
        .S_OUT  (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got Q=%b S_OUT=%b, want Q=%b S_OUT=%b",
                     tag, obs[4:1], obs[0], exp[4:1], exp[0]);
        end
    endtask

    // Apply one cycle of inputs, queue the expectation, clock, then compare.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic dr, input logic si, input logic [1:0] m,
                        input logic [3:0] dd, input logic [3:0] eq, input logic es);
        logic [4:0] exp;
        rst_n = r; enb = e; dir = dr; s_in = si; modo = m; d = dd;
        sb_q.push_back({eq, es});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, {q, s_out}, exp);
        end
    endtask

    // Reference model, written bit-by-bit.
    function automatic logic [4:0] ref_next(input logic [3:0] cq, input logic cs,
                                            input logic r, input logic e, input logic dr,
                                            input logic si, input logic [1:0] m,
                                            input logic [3:0] dd);
        logic [3:0] nq;
        logic       ns;
        if (!r) return 5'b0;
        if (!e) return {cq, cs};
        nq = cq; ns = 1'b0;
        if (m == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (dr) nq[i] = (i == 3) ? si : cq[i+1];
                else    nq[i] = (i == 0) ? si : cq[i-1];
            end
            ns = dr ? cq[0] : cq[3];
        end else if (m == 2'b10) begin
            nq = dd;
        end else if (m == 2'b01) begin
`ifdef SHIFT_REG_ROTATE_EN
            for (int i = 0; i < 4; i++)
                nq[i] = dr ? cq[(i+1)%4] : cq[(i+3)%4];
`endif
        end
        return {nq, ns};
    endfunction

    logic [3:0] rot_exp[4];

    initial begin
        rst_n = 1'b0; enb = 1'b0; dir = 1'b0; s_in = 1'b0; modo = 2'b11; d = 4'h0;
        @(negedge clk);

        // reset then load
        step("reset",      0, 1, 0, 1, 2'b10, 4'hF, 4'b0000, 0);
        step("load_1010",  1, 1, 0, 0, 2'b10, 4'b1010, 4'b1010, 0);

        // shift left, flushing 1011 MSB-first
        step("ld_1011",    1, 1, 0, 0, 2'b10, 4'b1011, 4'b1011, 0);
        step("shl_1",      1, 1, 0, 0, 2'b00, 4'hF, 4'b0110, 1);
        step("shl_2",      1, 1, 0, 0, 2'b00, 4'hF, 4'b1100, 0);
        step("shl_3",      1, 1, 0, 0, 2'b00, 4'hF, 4'b1000, 1);
        step("shl_4",      1, 1, 0, 0, 2'b00, 4'hF, 4'b0000, 1);

        // shift right with serial fill of ones
        step("ld_0000",    1, 1, 0, 0, 2'b10, 4'b0000, 4'b0000, 0);
        step("shr_1",      1, 1, 1, 1, 2'b00, 4'h0, 4'b1000, 0);
        step("shr_2",      1, 1, 1, 1, 2'b00, 4'h0, 4'b1100, 0);
        step("shr_3",      1, 1, 1, 1, 2'b00, 4'h0, 4'b1110, 0);
        step("shr_4",      1, 1, 1, 1, 2'b00, 4'h0, 4'b1111, 0);

        // rotate left from 1001 (holds when rotate is not built)
`ifdef SHIFT_REG_ROTATE_EN
        rot_exp = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
`else
        rot_exp = '{4'b1001, 4'b1001, 4'b1001, 4'b1001};
`endif
        step("ld_1001",    1, 1, 0, 0, 2'b10, 4'b1001, 4'b1001, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("rotl_%0d", i+1), 1, 1, 0, 1, 2'b01, 4'hF, rot_exp[i], 0);

        // enable gating
        step("ld_0101",    1, 1, 0, 0, 2'b10, 4'b0101, 4'b0101, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("enb0_%0d", i+1), 1, 0, 0, 1, 2'b00, 4'hF, 4'b0101, 0);
        step("enb1_shl",   1, 1, 0, 0, 2'b00, 4'h0, 4'b1010, 0);
        step("shl_s1",     1, 1, 0, 0, 2'b00, 4'h0, 4'b0100, 1);
        step("enb0_keep1", 1, 0, 1, 1, 2'b10, 4'hF, 4'b0100, 1);
        step("enb0_keep2", 1, 0, 0, 0, 2'b11, 4'h3, 4'b0100, 1);

        // reset mid-shift, then reload
        step("ld_1111",    1, 1, 0, 0, 2'b10, 4'b1111, 4'b1111, 0);
        step("mid_shl",    1, 1, 0, 0, 2'b00, 4'h0, 4'b1110, 1);
        step("mid_rst",    0, 1, 0, 0, 2'b00, 4'h0, 4'b0000, 0);
        step("rst_enb0",   0, 0, 0, 0, 2'b10, 4'hF, 4'b0000, 0);
        step("ld_0110",    1, 1, 0, 0, 2'b10, 4'b0110, 4'b0110, 0);

        // hold clears S_OUT, right shift emits LSB
        step("shl_fill1",  1, 1, 0, 1, 2'b00, 4'h0, 4'b1101, 0);
        step("shl_out1",   1, 1, 0, 1, 2'b00, 4'h0, 4'b1011, 1);
        step("hold",       1, 1, 1, 1, 2'b11, 4'h0, 4'b1011, 0);
        step("shr_out1",   1, 1, 1, 0, 2'b00, 4'h0, 4'b0101, 1);

        // random phase against the reference model
        m_q = 4'b0101; m_s = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic       r, e, dr, si;
            logic [1:0] m;
            logic [3:0] dd;
            logic [4:0] nx;
            r  = ($urandom_range(0, 15) != 0);
            e  = ($urandom_range(0, 4) != 0);
            dr = 1'($urandom);
            si = 1'($urandom);
            m  = 2'($urandom);
            dd = 4'($urandom);
            nx = ref_next(m_q, m_s, r, e, dr, si, m, dd);
            step($sformatf("rand_%0d", i), r, e, dr, si, m, dd, nx[4:1], nx[0]);
            m_q = nx[4:1];
            m_s = nx[0];
        end

        if (sb_q.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register_4.md
# shift_register_4

4-bit universal shift register with serial-in/serial-out, rotate and parallel load, selected by a 2-bit mode code. It is the storage element exercised by the register test suite, Test1 through Test3. Up to five independent instances are driven side by side, each by its own stimulus generator. All state changes occur on the rising clock edge.

## Interface
Parameters:
- none (width fixed at 4 bits)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK
- ENB  input  1  enable; 0 freezes Q and S_OUT
- DIR  input  1  direction; 0 = left (toward Q[3]), 1 = right (toward Q[0])
- S_IN  input  1  serial data in for shift mode
- MODO  input  2  mode select: 00 shift, 01 rotate, 10 parallel load, 11 hold
- D  input  4  parallel load data
- Q  output  4  register contents, registered
- S_OUT  output  1  serial out, registered

One clock; reset is synchronous and active-low.

## Operation
Priority at each rising CLK edge: RESET_N=0 first, then ENB=0, then MODO.

- RESET_N=0: Q<=4'b0000 and S_OUT<=0, regardless of ENB, MODO and the other inputs.
- ENB=0: Q and S_OUT hold their values.
- MODO=00, shift:
  - DIR=0: Q<={Q[2:0],S_IN} and S_OUT<=Q[3].
  - DIR=1: Q<={S_IN,Q[3:1]} and S_OUT<=Q[0].
- MODO=01, rotate:
  - DIR=0: Q<={Q[2:0],Q[3]}.
  - DIR=1: Q<={Q[0],Q[3:1]}.
  - S_OUT<=0 in both directions.
- MODO=10, parallel load: Q<=D and S_OUT<=0.
- MODO=11, hold: Q holds and S_OUT<=0.
- DIR and S_IN are ignored outside shift mode. D is ignored outside load mode.
- X or Z on MODO is treated as hold. Q keeps its value and S_OUT is driven to 0.

## Timing
- Every function has 1-cycle latency. Inputs are sampled at the rising edge, and Q and S_OUT update at that same edge.
- There are no combinational paths from inputs to outputs.
- S_OUT reflects the bit shifted out during the most recent enabled shift cycle. It stays valid until the next enabled edge.
- Reset is synchronous: asserting RESET_N without a clock edge has no effect.
  - When RESET_N is asserted mid-operation, the register clears at the next edge.
  - When RESET_N is deasserted, operation resumes at the first edge where RESET_N=1.
- When ENB falls mid-shift, the sequence pauses with Q and S_OUT intact. It resumes from the same state when ENB rises again.
- A change of mode or direction takes effect on the very edge that samples it. No extra cycle is inserted.
- Four consecutive shift cycles in the same direction fully flush the register. The initial contents emerge on S_OUT MSB-first when DIR=0 and LSB-first when DIR=1.
- Four consecutive rotate cycles return Q to its original value (wrap-around).

## Configuration
- Macro: SHIFT_REG_ROTATE_EN.
- Defined: MODO=01 performs rotation as described in Operation.
- Undefined: MODO=01 behaves exactly like MODO=11 (Q holds, S_OUT<=0). The rotate multiplexer path is not synthesized.
- All other modes are identical in both builds.

## Test plan
- Reset: with RESET_N=0 and ENB=1, one edge -> Q=0000 and S_OUT=0. Then RESET_N=1, MODO=10 and D=1010, one edge -> Q=1010.
- Shift left: load D=1011, then MODO=00, DIR=0, S_IN=0 for 4 edges -> S_OUT sequence 1,0,1,1 and Q sequence 0110,1100,1000,0000.
- Shift right with serial fill: load 0000, then MODO=00, DIR=1, S_IN=1 for 4 edges -> Q sequence 1000,1100,1110,1111 and S_OUT=0 throughout.
- Rotate (SHIFT_REG_ROTATE_EN defined): load 1001, then MODO=01, DIR=0 -> Q sequence 0011,0110,1100,1001 and S_OUT=0. Repeat without the macro -> Q stays 1001.
- Enable gating: load 0101, then ENB=0, MODO=00, DIR=0 for 3 edges -> Q=0101 and S_OUT unchanged. Then ENB=1 for one edge -> Q=1010 with S_IN=0, and S_OUT=0.
- Reset mid-shift: during a shift left from 1111, drive RESET_N=0 on the 2nd edge -> Q=0000 and S_OUT=0 at that edge. Release and load 0110 -> Q=0110.
